// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - core/DMA request, response and BRAM port bundle for the data-memory arbiter
interface dmem_port_arbiter_if #(
  parameter int AWIDTH = 14
);
  logic              core_req;
  logic [3:0]        core_we;
  logic [AWIDTH-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_stall;
  logic [31:0]       core_rdata;
  logic              core_rvalid;

  logic              dma_req;
  logic [3:0]        dma_we;
  logic [AWIDTH-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_ready;
  logic [31:0]       dma_rdata;
  logic              dma_rvalid;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter side: consumes requests and BRAM read data, drives everything else.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_stall, core_rdata, core_rvalid,
    output dma_ready, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: requesters plus the BRAM.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_stall, core_rdata, core_rvalid,
    input  dma_ready, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - fixed-priority core/DMA arbiter for the single data-memory BRAM port
module dmem_port_arbiter #(
  parameter int AWIDTH   = 14,
  parameter int MAX_WAIT = 8
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;   // 0 = core, 1 = DMA
  logic              core_gnt, dma_gnt;
  logic              mem_en_d;
  logic [3:0]        mem_we_d;
  logic [AWIDTH-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;

  // Grant decision: core wins unless a starved DMA has reached its limit; nothing is granted in reset.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!rst) begin
      core_gnt = bus.core_req && !(bus.dma_req && (wait_cnt_q == WAIT_LIMIT));
      dma_gnt  = bus.dma_req && !core_gnt;
    end
  end

  // BRAM port mux: drive the granted requester's fields, zeros when idle.
  always_comb begin
    mem_en_d    = core_gnt || dma_gnt;
    mem_we_d    = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = 32'h0;
    if (core_gnt) begin
      mem_we_d    = bus.core_we;
      mem_addr_d  = bus.core_addr;
      mem_wdata_d = bus.core_wdata;
    end else if (dma_gnt) begin
      mem_we_d    = bus.dma_we;
      mem_addr_d  = bus.dma_addr;
      mem_wdata_d = bus.dma_wdata;
    end
  end

  // Next state: saturating starvation counter and the tag of the read now in flight.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dma_gnt || !bus.dma_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    resp_valid_d = mem_en_d && (mem_we_d == 4'b0000);
    resp_id_d    = dma_gnt;
  end

  // State registers; reset drops any in-flight read tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign bus.mem_en      = mem_en_d;
  assign bus.mem_we      = mem_we_d;
  assign bus.mem_addr    = mem_addr_d;
  assign bus.mem_wdata   = mem_wdata_d;
  assign bus.core_stall  = !rst && bus.core_req && !core_gnt;
  assign bus.dma_ready   = dma_gnt;
  // Response valids are masked during reset so a read caught by reset never reports back.
  assign bus.core_rvalid = !rst && resp_valid_q && !resp_id_q;
  assign bus.dma_rvalid  = !rst && resp_valid_q && resp_id_q;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.dma_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  localparam int AWIDTH   = 14;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_port_arbiter_if #(.AWIDTH(AWIDTH)) bus ();

  dmem_port_arbiter #(.AWIDTH(AWIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_req   = 1'b0;
    bus.core_we    = 4'b0000;
    bus.core_addr  = '0;
    bus.core_wdata = 32'h0;
    bus.dma_req    = 1'b0;
    bus.dma_we     = 4'b0000;
    bus.dma_addr   = '0;
    bus.dma_wdata  = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.mem_rdata = 32'h0;
    rst = 1'b1;
    bus.core_req = 1'b1;
    bus.dma_req  = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
    checks++; if (bus.mem_we !== 4'b0000) begin errors++; $display("FAIL reset_mem_we: got %b expected 0000", bus.mem_we); end
    checks++; if (bus.core_stall !== 1'b0) begin errors++; $display("FAIL reset_core_stall: got %b expected 0", bus.core_stall); end
    checks++; if (bus.dma_ready !== 1'b0) begin errors++; $display("FAIL reset_dma_ready: got %b expected 0", bus.dma_ready); end
    checks++; if (bus.core_rvalid !== 1'b0) begin errors++; $display("FAIL reset_core_rvalid: got %b expected 0", bus.core_rvalid); end
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dma_rvalid: got %b expected 0", bus.dma_rvalid); end
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (dut.wait_cnt_q !== '0) begin errors++; $display("FAIL reset_wait_cnt: got %0d expected 0", dut.wait_cnt_q); end
    checks++; if (bus.core_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_release_rvalid: got %b%b expected 00", bus.core_rvalid, bus.dma_rvalid); end
    step();
  endtask

  task automatic test_core_read();
    bus.core_req  = 1'b1;
    bus.core_we   = 4'b0000;
    bus.core_addr = 14'h010;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL core_read_mem_en: got %b expected 1", bus.mem_en); end
    checks++; if (bus.mem_addr !== 14'h010) begin errors++; $display("FAIL core_read_mem_addr: got %h expected 010", bus.mem_addr); end
    checks++; if (bus.mem_we !== 4'b0000) begin errors++; $display("FAIL core_read_mem_we: got %b expected 0000", bus.mem_we); end
    checks++; if (bus.core_stall !== 1'b0) begin errors++; $display("FAIL core_read_stall: got %b expected 0", bus.core_stall); end
    step();
    idle_inputs();
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.core_rvalid !== 1'b1) begin errors++; $display("FAIL core_read_rvalid: got %b expected 1", bus.core_rvalid); end
    checks++; if (bus.core_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL core_read_rdata: got %h expected deadbeef", bus.core_rdata); end
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL core_read_dma_rvalid: got %b expected 0", bus.dma_rvalid); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL core_read_idle_mem_en: got %b expected 0", bus.mem_en); end
    step();
    bus.mem_rdata = 32'h0;
  endtask

  task automatic test_contention();
    bus.core_req  = 1'b1;
    bus.core_addr = 14'h100;
    bus.dma_req   = 1'b1;
    bus.dma_addr  = 14'h200;
    for (int i = 0; i < 2 * (MAX_WAIT + 1); i++) begin
      logic exp_dma;
      exp_dma = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
      @(negedge clk);
      checks++; if (bus.dma_ready !== exp_dma) begin errors++; $display("FAIL contention_dma_ready[%0d]: got %b expected %b", i, bus.dma_ready, exp_dma); end
      checks++; if (bus.core_stall !== exp_dma) begin errors++; $display("FAIL contention_core_stall[%0d]: got %b expected %b", i, bus.core_stall, exp_dma); end
      checks++; if (bus.mem_addr !== (exp_dma ? 14'h200 : 14'h100)) begin errors++; $display("FAIL contention_mem_addr[%0d]: got %h expected %h", i, bus.mem_addr, exp_dma ? 14'h200 : 14'h100); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_dma_write();
    bus.dma_req   = 1'b1;
    bus.dma_we    = 4'b0011;
    bus.dma_addr  = 14'h3FF;
    bus.dma_wdata = 32'h0000ABCD;
    @(negedge clk);
    checks++; if (bus.dma_ready !== 1'b1) begin errors++; $display("FAIL dma_write_ready: got %b expected 1", bus.dma_ready); end
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL dma_write_mem_en: got %b expected 1", bus.mem_en); end
    checks++; if (bus.mem_we !== 4'b0011) begin errors++; $display("FAIL dma_write_mem_we: got %b expected 0011", bus.mem_we); end
    checks++; if (bus.mem_addr !== 14'h3FF) begin errors++; $display("FAIL dma_write_mem_addr: got %h expected 3ff", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0000ABCD) begin errors++; $display("FAIL dma_write_mem_wdata: got %h expected 0000abcd", bus.mem_wdata); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL dma_write_no_dma_rvalid: got %b expected 0", bus.dma_rvalid); end
    checks++; if (bus.core_rvalid !== 1'b0) begin errors++; $display("FAIL dma_write_no_core_rvalid: got %b expected 0", bus.core_rvalid); end
    step();
  endtask

  task automatic test_back_to_back();
    bus.core_req  = 1'b1;
    bus.core_addr = 14'h004;
    @(negedge clk);
    checks++; if (bus.mem_addr !== 14'h004) begin errors++; $display("FAIL b2b_core_addr: got %h expected 004", bus.mem_addr); end
    step();
    idle_inputs();
    bus.dma_req   = 1'b1;
    bus.dma_addr  = 14'h008;
    bus.mem_rdata = 32'h11112222;
    @(negedge clk);
    checks++; if (bus.core_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_core_rvalid_n1: got %b expected 1", bus.core_rvalid); end
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_dma_rvalid_n1: got %b expected 0", bus.dma_rvalid); end
    checks++; if (bus.core_rdata !== 32'h11112222) begin errors++; $display("FAIL b2b_core_rdata: got %h expected 11112222", bus.core_rdata); end
    checks++; if (bus.dma_ready !== 1'b1) begin errors++; $display("FAIL b2b_dma_ready: got %b expected 1", bus.dma_ready); end
    checks++; if (bus.mem_addr !== 14'h008) begin errors++; $display("FAIL b2b_dma_addr: got %h expected 008", bus.mem_addr); end
    step();
    idle_inputs();
    bus.mem_rdata = 32'h33334444;
    @(negedge clk);
    checks++; if (bus.core_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_core_rvalid_n2: got %b expected 0", bus.core_rvalid); end
    checks++; if (bus.dma_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_dma_rvalid_n2: got %b expected 1", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 32'h33334444) begin errors++; $display("FAIL b2b_dma_rdata: got %h expected 33334444", bus.dma_rdata); end
    step();
    bus.mem_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_read();
    bus.core_req  = 1'b1;
    bus.core_addr = 14'h020;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL midrst_grant: got %b expected 1", bus.mem_en); end
    step();
    idle_inputs();
    rst = 1'b1;
    bus.mem_rdata = 32'h55555555;
    @(negedge clk);
    checks++; if (bus.core_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_core_rvalid_in_rst: got %b expected 0", bus.core_rvalid); end
    step();
    rst = 1'b0;
    bus.core_req  = 1'b1;
    bus.core_addr = 14'h030;
    @(negedge clk);
    checks++; if (bus.core_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_core_rvalid_after: got %b expected 0", bus.core_rvalid); end
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 14'h030) begin errors++; $display("FAIL midrst_resume_grant: got en=%b addr=%h expected en=1 addr=030", bus.mem_en, bus.mem_addr); end
    step();
    idle_inputs();
    bus.mem_rdata = 32'h66666666;
    @(negedge clk);
    checks++; if (bus.core_rvalid !== 1'b1) begin errors++; $display("FAIL midrst_resume_rvalid: got %b expected 1", bus.core_rvalid); end
    checks++; if (bus.core_rdata !== 32'h66666666) begin errors++; $display("FAIL midrst_resume_rdata: got %h expected 66666666", bus.core_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_contention();
    test_dma_write();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
